// File: rtl/inst_loop_sequencer.sv
// Program sequencer for the HDC encoder instruction path: owns the PC, gates the
// decoder and runs up to NumLoops nested zero-overhead hardware loops.
module inst_loop_sequencer #(
   parameter  int InstMemDepth  = 64,
   parameter  int NumLoops      = 2,
   parameter  int LoopCntWidth  = 10,
   localparam int InstAddrWidth = $clog2(InstMemDepth)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              start_i,
   input  logic                              clr_i,
   input  logic                              stall_i,
   input  logic [InstAddrWidth-1:0]          last_addr_i,
   input  logic [NumLoops*InstAddrWidth-1:0] loop_start_addr_i,
   input  logic [NumLoops*InstAddrWidth-1:0] loop_end_addr_i,
   input  logic [NumLoops*LoopCntWidth-1:0]  loop_count_i,
   output logic [InstAddrWidth-1:0]          inst_addr_o,
   output logic                              inst_en_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic [NumLoops*LoopCntWidth-1:0]  loop_iter_o
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   localparam logic [InstAddrWidth-1:0] LastMemAddr = InstAddrWidth'(InstMemDepth - 1);

   logic [0:0]               state_q, state_d;
   logic [InstAddrWidth-1:0] pc_q, pc_d;
   logic [LoopCntWidth-1:0]  cnt_q [NumLoops];
   logic [LoopCntWidth-1:0]  cnt_d [NumLoops];
   logic                     done_q, done_d;

   logic [NumLoops-1:0]      at_end;
   logic [NumLoops-1:0]      can_repeat;
   logic [InstAddrWidth-1:0] loop_start [NumLoops];

   logic                     jump;
   logic [NumLoops-1:0]      jump_sel;
   logic [InstAddrWidth-1:0] jump_target;
   logic                     below_jump;
   logic                     running;

   assign running = (state_q == StRun);

   // Per-loop decode: a loop repeats while its counter is below max(count,1)-1.
   for (genvar g = 0; g < NumLoops; g++) begin : g_loop
      logic [InstAddrWidth-1:0] end_addr;
      logic [LoopCntWidth-1:0]  total;
      logic [LoopCntWidth-1:0]  last_iter;

      assign end_addr      = loop_end_addr_i[g*InstAddrWidth +: InstAddrWidth];
      assign loop_start[g] = loop_start_addr_i[g*InstAddrWidth +: InstAddrWidth];
      assign total         = loop_count_i[g*LoopCntWidth +: LoopCntWidth];
      assign last_iter     = (total == '0) ? '0 : total - LoopCntWidth'(1);
      assign at_end[g]     = (pc_q == end_addr);
      assign can_repeat[g] = at_end[g] && (cnt_q[g] < last_iter);

      assign loop_iter_o[g*LoopCntWidth +: LoopCntWidth] = cnt_q[g];
   end

   // The innermost loop that can still repeat wins the jump.
   always_comb begin
      jump        = 1'b0;
      jump_sel    = '0;
      jump_target = '0;
      for (int j = 0; j < NumLoops; j++) begin
         if (!jump && can_repeat[j]) begin
            jump        = 1'b1;
            jump_sel[j] = 1'b1;
            jump_target = loop_start[j];
         end
      end
   end

   // Next-state logic; clear overrides everything, including a pending start or issue.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      below_jump = 1'b1;

      case (state_q)
         StIdle: begin
            pc_d = '0;
            if (start_i) begin
               state_d = StRun;
               for (int j = 0; j < NumLoops; j++) begin
                  cnt_d[j] = '0;
               end
            end
         end
         StRun: begin
            if (!stall_i) begin
               for (int j = 0; j < NumLoops; j++) begin
                  if (jump_sel[j]) begin
                     cnt_d[j]   = cnt_q[j] + LoopCntWidth'(1);
                     below_jump = 1'b0;
                  end else if (below_jump && at_end[j]) begin
                     cnt_d[j] = '0;
                  end
               end

               if (jump) begin
                  pc_d = jump_target;
               end else if (pc_q == last_addr_i) begin
                  state_d = StIdle;
                  pc_d    = '0;
                  done_d  = 1'b1;
                  for (int j = 0; j < NumLoops; j++) begin
                     cnt_d[j] = '0;
                  end
               end else if (pc_q == LastMemAddr) begin
                  pc_d = '0;
               end else begin
                  pc_d = pc_q + InstAddrWidth'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            pc_d    = '0;
         end
      endcase

      if (clr_i) begin
         state_d = StIdle;
         pc_d    = '0;
         done_d  = 1'b0;
         for (int j = 0; j < NumLoops; j++) begin
            cnt_d[j] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         pc_q    <= '0;
         done_q  <= 1'b0;
         for (int j = 0; j < NumLoops; j++) begin
            cnt_q[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
         for (int j = 0; j < NumLoops; j++) begin
            cnt_q[j] <= cnt_d[j];
         end
      end
   end

   // Instruction memory is read asynchronously, so decode enable follows stall directly.
   assign inst_addr_o = pc_q;
   assign inst_en_o   = running && !stall_i;
   assign busy_o      = running;
   assign done_o      = done_q;

endmodule
